// File: rtl/microwave_ctrl_if.sv
// Signal bundle between the front-panel sequencer, the debounced
// panel inputs and the countdown timer.
interface microwave_ctrl_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] timer_data;
    logic       timer_loadn;
    logic       timer_clrn;
    logic       timer_en;
    logic       mag_on;
    logic       beep;
    logic [2:0] state;

    modport slave (
        input  digit, digit_valid, start, stop, door_closed, timer_zero,
        output timer_data, timer_loadn, timer_clrn, timer_en,
        output mag_on, beep, state
    );

    modport master (
        output digit, digit_valid, start, stop, door_closed, timer_zero,
        input  timer_data, timer_loadn, timer_clrn, timer_en,
        input  mag_on, beep, state
    );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave front-panel sequencer: keypad entry, cook/pause/abort control,
// 1 Hz prescaler for the countdown timer, magnetron and end-of-cook beep.
module microwave_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int BEEP_CYCLES = 300
) (
    input logic             clock,
    input logic             clrn,
    microwave_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLEN = BW'(BEEP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic [PW-1:0] r_pre;
    logic [BW-1:0] r_bcnt;
    logic [3:0]    r_data;
    logic          r_loadn;
    logic          r_tclrn;
    logic          r_en;
    logic          r_mag;
    logic          r_beep;
    logic          w_dig_ok;
    logic          w_start_ok;

    assign w_dig_ok = bus.digit_valid && (bus.digit <= 4'd9)
                   && !bus.start && !bus.stop;
    // a load issued last cycle has not yet reached timer_zero
    assign w_start_ok = bus.door_closed && !bus.timer_zero && r_loadn;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_pre   <= '0;
            r_bcnt  <= '0;
            r_data  <= 4'd0;
            r_loadn <= 1'b1;
            r_tclrn <= 1'b0;
            r_en    <= 1'b0;
            r_mag   <= 1'b0;
            r_beep  <= 1'b0;
        end else begin
            r_loadn <= 1'b1;
            r_tclrn <= 1'b1;
            r_en    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_dig_ok) begin
                        r_data  <= bus.digit;
                        r_loadn <= 1'b0;
                        r_cnt   <= 2'd1;
                        r_state <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (bus.stop) begin
                        r_tclrn <= 1'b0;
                        r_cnt   <= 2'd0;
                        r_state <= IDLE;
                    end else if (bus.start) begin
                        if (w_start_ok) begin
                            r_pre   <= '0;
                            r_mag   <= 1'b1;
                            r_state <= COOK;
                        end
                    end else if (w_dig_ok && r_cnt != 2'd3) begin
                        r_data  <= bus.digit;
                        r_loadn <= 1'b0;
                        r_cnt   <= r_cnt + 2'd1;
                    end
                end
                COOK: begin
                    if (bus.timer_zero) begin
                        r_mag   <= 1'b0;
                        r_beep  <= 1'b1;
                        r_bcnt  <= BLEN;
                        r_state <= DONE;
                    end else if (!bus.door_closed || bus.stop) begin
                        // a completed second stays owed across the pause
                        if (r_pre != LAST)
                            r_pre <= r_pre + 1'b1;
                        r_mag   <= 1'b0;
                        r_state <= PAUSE;
                    end else if (r_pre == LAST) begin
                        r_pre <= '0;
                        r_en  <= 1'b1;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        r_tclrn <= 1'b0;
                        r_cnt   <= 2'd0;
                        r_state <= IDLE;
                    end else if (bus.start && bus.door_closed) begin
                        r_mag   <= 1'b1;
                        r_state <= COOK;
                    end
                end
                DONE: begin
                    if (bus.stop || r_bcnt == '0) begin
                        r_beep  <= 1'b0;
                        r_tclrn <= 1'b0;
                        r_cnt   <= 2'd0;
                        r_state <= IDLE;
                    end else begin
                        r_bcnt <= r_bcnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.timer_data  = r_data;
    assign bus.timer_loadn = r_loadn;
    assign bus.timer_clrn  = r_tclrn;
    assign bus.timer_en    = r_en;
    assign bus.mag_on      = r_mag;
    assign bus.beep        = r_beep;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed panel scenarios plus random panel
// activity, compared cycle by cycle against a behavioural oven model.
module tb_microwave_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int BEEP_CYCLES = 5;

    logic clock;
    logic clrn;
    microwave_ctrl_if bus ();

    microwave_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .BEEP_CYCLES (BEEP_CYCLES)
    ) dut (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // countdown timer the sequencer drives (m:ss, shift-loaded digits)
    logic [3:0] t_min, t_ten, t_one;
    always @(posedge clock or negedge bus.timer_clrn) begin
        if (!bus.timer_clrn) begin
            t_min <= 4'd0; t_ten <= 4'd0; t_one <= 4'd0;
        end else if (!bus.timer_loadn) begin
            t_min <= t_ten; t_ten <= t_one; t_one <= bus.timer_data;
        end else if (bus.timer_en) begin
            if (t_one != 0) t_one <= t_one - 4'd1;
            else if (t_ten != 0) begin
                t_ten <= t_ten - 4'd1; t_one <= 4'd9;
            end else if (t_min != 0) begin
                t_min <= t_min - 4'd1; t_ten <= 4'd5; t_one <= 4'd9;
            end
        end
    end
    assign bus.timer_zero = ({t_min, t_ten, t_one} == 12'd0);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic door  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference oven: mode 0 idle,1 entry,2 cook,3 pause,4 done
    int         m_mode, m_digits, m_credit, m_beep_left;
    logic       e_loadn, e_tclrn, e_en;
    logic [3:0] e_data;

    task automatic m_reset();
        m_mode = 0; m_digits = 0; m_credit = 0; m_beep_left = 0;
        e_loadn = 1'b1; e_tclrn = 1'b0; e_en = 1'b0; e_data = 4'd0;
    endtask

    task automatic m_abort();
        e_tclrn = 1'b0; m_digits = 0; m_mode = 0;
    endtask

    task automatic m_step(input logic dv, input logic [3:0] dg,
                          input logic st, input logic sp,
                          input logic dc, input logic tz);
        logic loaded_last;
        logic key_ok;
        loaded_last = !e_loadn;
        key_ok = dv && dg < 10 && !st && !sp;
        e_loadn = 1'b1; e_tclrn = 1'b1; e_en = 1'b0;
        case (m_mode)
            0: if (key_ok) begin
                e_data = dg; e_loadn = 1'b0; m_digits = 1; m_mode = 1;
            end
            1: if (sp) m_abort();
               else if (st) begin
                   if (dc && !tz && !loaded_last) begin
                       m_mode = 2; m_credit = 0;
                   end
               end else if (key_ok && m_digits < 3) begin
                   e_data = dg; e_loadn = 1'b0; m_digits++;
               end
            2: begin
                if (m_credit < TICK_DIV) m_credit++;
                if (tz) begin
                    m_mode = 4; m_beep_left = BEEP_CYCLES;
                end else if (!dc || sp) m_mode = 3;
                else if (m_credit == TICK_DIV) begin
                    e_en = 1'b1; m_credit = 0;
                end
            end
            3: if (sp) m_abort();
               else if (st && dc) m_mode = 2;
            4: begin
                m_beep_left--;
                if (sp || m_beep_left == 0) m_abort();
            end
            default: m_mode = 0;
        endcase
    endtask

    function automatic logic [11:0] dut_vec();
        return {bus.state, bus.mag_on, bus.beep, bus.timer_en,
                bus.timer_loadn, bus.timer_clrn, bus.timer_data};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {3'(m_mode), m_mode == 2, m_mode == 4, e_en,
                e_loadn, e_tclrn, e_data};
    endfunction

    // called just after a rising edge; applies inputs for the next one
    task automatic step(input logic dv, input logic [3:0] dg,
                        input logic st, input logic sp);
        logic tz;
        bus.digit_valid = dv; bus.digit = dg;
        bus.start = st; bus.stop = sp; bus.door_closed = door;
        tz = bus.timer_zero;
        @(posedge clock);
        m_step(dv, dg, st, sp, door, tz);
        cyc++;
        #1;
        chk("outs", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic idle();       step(1'b0, 4'd0, 1'b0, 1'b0); endtask
    task automatic key(input logic [3:0] d); step(1'b1, d, 1'b0, 1'b0); endtask
    task automatic press_start(); step(1'b0, 4'd0, 1'b1, 1'b0); endtask
    task automatic press_stop();  step(1'b0, 4'd0, 1'b0, 1'b1); endtask

    function automatic logic [11:0] tshow();
        return {t_min, t_ten, t_one};
    endfunction

    initial begin
        int last, en_n, beep_n, act;
        logic [3:0] seq [3];
        bus.digit = 4'd0; bus.digit_valid = 1'b0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.door_closed = 1'b1;
        clrn = 1'b0;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset", 32'(dut_vec()), 32'(12'b000_0_0_0_1_0_0000));
        #3 clrn = 1'b1;

        // entry of 1:30, then a 4th digit
        seq[0] = 4'd1; seq[1] = 4'd3; seq[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            key(seq[i]);
            chk("load", {bus.timer_loadn, bus.timer_data}, {1'b0, seq[i]});
        end
        idle();
        chk("t130", tshow(), 12'h130);
        chk("entry", bus.state, 3'd1);
        key(4'd7);
        chk("4th", bus.timer_loadn, 1'b1);
        press_stop();

        // full cook of 0:05
        key(4'd5);
        idle();
        press_start();
        chk("mag", bus.mag_on, 1'b1);
        last = cyc; en_n = 0;
        for (int i = 0; i < 80 && bus.state != 3'd4; i++) begin
            idle();
            if (bus.timer_en) begin
                en_n++;
                chk("en_gap", cyc - last, TICK_DIV);
                last = cyc;
            end
        end
        chk("en_cnt", en_n, 5);
        chk("done_mag", {bus.state, bus.mag_on}, {3'd4, 1'b0});
        beep_n = int'(bus.beep);
        for (int i = 0; i < 20 && bus.state == 3'd4; i++) begin
            idle();
            if (bus.beep) beep_n++;
        end
        chk("beep_len", beep_n, BEEP_CYCLES);
        chk("done_clr", {bus.state, bus.timer_clrn}, {3'd0, 1'b0});

        // door interlock and pause/resume
        key(4'd2);
        idle();
        door = 1'b0;
        press_start();
        chk("door_ign", bus.state, 3'd1);
        door = 1'b1;
        press_start();
        idle(); idle();
        door = 1'b0;
        idle();
        chk("pause", {bus.state, bus.mag_on}, {3'd3, 1'b0});
        idle();
        door = 1'b1;
        press_start();
        idle();
        chk("resume_en", bus.timer_en, 1'b1);

        // abort from pause
        door = 1'b0;
        idle();
        door = 1'b1;
        press_stop();
        chk("abort", {bus.state, bus.timer_clrn}, {3'd0, 1'b0});
        idle();
        chk("abort_1cyc", bus.timer_clrn, 1'b1);
        chk("abort_tmr", tshow(), 12'h000);

        // zero timer and load hazard
        key(4'd0);
        idle();
        press_start();
        chk("zero_ign", bus.state, 3'd1);
        key(4'd5);
        idle();
        key(4'd3);
        press_start();
        chk("hazard", bus.state, 3'd1);
        press_start();
        chk("cook53", bus.state, 3'd2);
        press_stop();
        press_stop();

        // timer_zero and door opening together
        key(4'd1);
        idle();
        press_start();
        for (int i = 0; i < 20 && !bus.timer_zero; i++) idle();
        door = 1'b0;
        idle();
        chk("zero_door", bus.state, 3'd4);
        door = 1'b1;
        press_stop();

        // stop and start together in entry
        key(4'd4);
        idle();
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("stop_start", {bus.state, bus.timer_clrn}, {3'd0, 1'b0});
        idle();
        chk("ss_tmr", tshow(), 12'h000);

        // reset mid-cook acts without a clock edge
        key(4'd9);
        idle();
        press_start();
        idle();
        #3 clrn = 1'b0;
        #1;
        chk("async_mag", {bus.state, bus.mag_on, bus.timer_clrn}, 5'b000_0_0);
        m_reset();
        #2 clrn = 1'b1;
        idle();
        chk("rst_tmr", tshow(), 12'h000);

        // random panel activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) door = !door;
            act = int'($urandom_range(0, 9));
            if (act <= 3) idle();
            else if (act <= 6) key(4'($urandom_range(0, 15)));
            else if (act <= 8) press_start();
            else press_stop();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/microwave_ctrl.md
# microwave_ctrl

Front-panel sequencer for the microwave's countdown timer. It shifts keypad digits into the `timer` block and starts, pauses and aborts cooking from the start, stop and door inputs. It also divides the system clock down to the 1 Hz count enable, drives the magnetron and raises the end-of-cook beep. It sits between the debounced panel inputs and the `timer` instance in the top level.

## Interface
Parameters:
- `TICK_DIV`, default 100: clock cycles per one-second count enable; must be 2 or more.
- `BEEP_CYCLES`, default 300: length of the end-of-cook beep, in clock cycles.

Ports:
- `clock`  in  1  system clock, rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `digit`  in  4  keypad BCD digit.
- `digit_valid`  in  1  one-cycle pulse; `digit` is valid in that cycle.
- `start`  in  1  one-cycle pulse, synchronized and debounced upstream.
- `stop`  in  1  one-cycle pulse, synchronized and debounced upstream.
- `door_closed`  in  1  level, synchronized; 1 means the door is closed.
- `timer_zero`  in  1  `zero` output of the timer.
- `timer_data`  out  4  digit presented to the timer's `data` input.
- `timer_loadn`  out  1  active-low shift-load strobe to the timer.
- `timer_clrn`  out  1  active-low clear to the timer.
- `timer_en`  out  1  one-cycle count-down enable to the timer.
- `mag_on`  out  1  magnetron enable.
- `beep`  out  1  buzzer drive.
- `state`  out  3  current state: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.

## Operation
- All outputs are registered.
- Reset values:
  - state=IDLE, timer_data=0, timer_loadn=1, timer_en=0, mag_on=0, beep=0.
  - timer_clrn=0, so the timer is held clear during reset; it returns to 1 on the first clock edge after `clrn` is released.
- Priority within one cycle: `stop` > `start` > `digit_valid`.
- Digit load:
  - An accepted digit (value 0-9) is registered onto `timer_data` with `timer_loadn`=0 for exactly one cycle.
  - On that load the timer shifts ones→tens→mins.
  - Digits of 10-15 are ignored.
  - A 2-bit counter limits entry to 3 digits; a 4th and later digit is ignored.
- Clear: an abort drives `timer_clrn`=0 for one cycle and resets the digit counter to 0.
- IDLE: a valid digit loads and moves to ENTRY with digit count 1. `start` and `stop` have no effect.
- ENTRY:
  - A valid digit loads while count < 3.
  - `stop` clears the timer and moves to IDLE.
  - `start` moves to COOK only if all of: `door_closed`=1, `timer_zero`=0, and no load was issued in the previous cycle. Otherwise `start` is ignored.
- COOK:
  - `mag_on`=1 and the prescaler runs; digits are ignored.
  - `timer_zero`=1 moves to DONE. This takes priority over the door opening and over `stop` in the same cycle.
  - Door opening or `stop` moves to PAUSE.
- PAUSE:
  - `mag_on`=0, and the prescaler holds its value.
  - `start` with the door closed returns to COOK.
  - `stop` clears the timer and moves to IDLE.
  - Digits are ignored.
- DONE:
  - `mag_on`=0 and `beep`=1 for BEEP_CYCLES cycles, then IDLE.
  - `stop` ends the beep early and goes to IDLE the next cycle.
  - Entering IDLE from DONE pulses `timer_clrn` and resets the digit count.
- Prescaler:
  - Width is ceil(log2(TICK_DIV)).
  - It is zeroed on the ENTRY→COOK transition and counts 0..TICK_DIV-1, wrapping.
  - `timer_en`=1 for one cycle when the count equals TICK_DIV-1 in COOK. It is never asserted outside COOK.
- Reset mid-operation: all outputs take their reset values asynchronously and immediately, including `mag_on`=0. The timer contents are cleared.

## Timing
- `digit_valid` at edge N → `timer_loadn` low during cycle N+1 → timer updates at edge N+2.
- An accepted `start` at edge N → state=COOK and `mag_on`=1 after edge N+1.
  - The first `timer_en` comes TICK_DIV cycles after entry to COOK.
  - Consecutive `timer_en` pulses are TICK_DIV cycles apart.
- PAUSE→COOK resumes the prescaler from its held value, so no partial second is lost or doubled.
- Door opening while in COOK → `mag_on`=0 one cycle after `door_closed` falls.
- `beep` stays high for exactly BEEP_CYCLES cycles.
- Back-to-back `digit_valid` pulses every cycle are all accepted, up to the 3-digit limit.

## Test plan
Bench settings: TICK_DIV=4, BEEP_CYCLES=5.

1. Reset and entry: assert and release reset, then enter digits 1, 3, 0.
   - Three one-cycle `timer_loadn` pulses carrying data 1, 3, 0.
   - The timer shows 1:30 and state=ENTRY.
   - A 4th digit 7 produces no load.
2. Full cook: enter 5, then `start` with the door closed.
   - `mag_on`=1.
   - `timer_en` every 4 cycles, 5 pulses in total.
   - `timer_zero` → state=DONE, `mag_on`=0, `beep` high for 5 cycles, then IDLE with a `timer_clrn` pulse.
3. Door interlock:
   - `start` with `door_closed`=0 is ignored and state stays ENTRY.
   - During COOK, opening the door at prescaler count 2 gives PAUSE and `mag_on`=0.
   - Closing the door then `start` gives the next `timer_en` 1 cycle after resuming.
4. Abort: in PAUSE, `stop` gives a one-cycle `timer_clrn` pulse and state=IDLE.
5. Zero and hazard:
   - Enter 0, then `start`: ignored because `timer_zero`=1.
   - A `start` in the cycle right after a digit load is ignored.
6. Simultaneous events:
   - `stop` and `start` together in ENTRY → IDLE with the timer cleared.
   - `timer_zero` and door opening together in COOK → DONE.
   - Asserting `clrn` during COOK drops `mag_on` immediately, without waiting for a clock edge.
